// File: rtl/daq_ram_ctrl_if.sv
// Bus bundle for the DAQ circular-buffer controller: writer, reader, status and RAM pins.
// slave = controller side, master = system/RAM side.
interface daq_ram_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              flush;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_req;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W:0]   level;
  logic              empty;
  logic              full;
  logic [7:0]        drop_count;
  logic              ram_ce;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_q;
  logic              ram_rst;

  modport slave (
    input  flush, wr_valid, wr_data, rd_req, ram_q,
    output wr_ready, rd_ready, rd_data, rd_valid, level, empty, full, drop_count,
           ram_ce, ram_we, ram_addr, ram_din, ram_rst
  );

  modport master (
    output flush, wr_valid, wr_data, rd_req, ram_q,
    input  wr_ready, rd_ready, rd_data, rd_valid, level, empty, full, drop_count,
           ram_ce, ram_we, ram_addr, ram_din, ram_rst
  );
endinterface

// File: rtl/daq_ram_ctrl.sv
// Circular-buffer controller for a single-port DAQ sample RAM, one access per clock.
// Optional macro DAQ_RAM_CTRL_DROP_EN: discard and count writes arriving while full.
module daq_ram_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter bit RR_ARB = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  daq_ram_ctrl_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  // Encoding chosen so ram_ce/ram_we are direct flop bits (glitch-free RAM control).
  typedef enum logic [1:0] {
    ISSUE_IDLE = 2'b00,
    ISSUE_RD   = 2'b01,
    ISSUE_WR   = 2'b11
  } issue_e;

  issue_e            state, state_nxt;
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   level_r, level_nxt;
  logic              empty_r, full_r;
  logic              last_wr;
  logic              rd_pend;
  logic              w_room, w_el, r_el, wr_rdy, rd_rdy;
  logic              acc_w, acc_r, store_w;

`ifdef DAQ_RAM_CTRL_DROP_EN
  assign w_room = 1'b1;
`else
  assign w_room = ~full_r;
`endif

  // Readies only look at registered flags and the opposite side's request.
  assign w_el    = bus.wr_valid & w_room & ~bus.flush;
  assign r_el    = bus.rd_req & ~empty_r & ~bus.flush;
  assign wr_rdy  = ~bus.flush & w_room & ~(r_el & RR_ARB & last_wr);
  assign rd_rdy  = ~bus.flush & ~empty_r & ~(w_el & (~RR_ARB | ~last_wr));
  assign acc_w   = bus.wr_valid & wr_rdy;
  assign acc_r   = bus.rd_req & rd_rdy;
  assign store_w = acc_w & ~full_r;

  always_comb begin
    level_nxt = level_r;
    if (bus.flush)    level_nxt = '0;
    else if (store_w) level_nxt = level_r + 1'b1;
    else if (acc_r)   level_nxt = level_r - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ISSUE_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = ISSUE_IDLE;
    if (store_w)    state_nxt = ISSUE_WR;
    else if (acc_r) state_nxt = ISSUE_RD;
  end

  always_comb begin
    bus.ram_ce = state[0];
    bus.ram_we = state[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      level_r      <= '0;
      empty_r      <= 1'b1;
      full_r       <= 1'b0;
      last_wr      <= 1'b0;
      rd_pend      <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_din  <= '0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      if (bus.flush) begin
        wptr <= '0;
        rptr <= '0;
      end else if (store_w) begin
        wptr         <= wptr + 1'b1;
        bus.ram_addr <= wptr;
        bus.ram_din  <= bus.wr_data;
      end else if (acc_r) begin
        rptr         <= rptr + 1'b1;
        bus.ram_addr <= rptr;
      end
      level_r <= level_nxt;
      empty_r <= (level_nxt == '0);
      full_r  <= (level_nxt == (ADDR_W+1)'(DEPTH));
      if (acc_w | acc_r) last_wr <= acc_w;
      // RAM samples the address one edge after issue; Q is captured the edge after that.
      rd_pend      <= (state == ISSUE_RD);
      bus.rd_valid <= rd_pend;
      if (rd_pend) bus.rd_data <= bus.ram_q;
    end
  end

`ifdef DAQ_RAM_CTRL_DROP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      bus.drop_count <= '0;
    else if (acc_w && full_r && bus.drop_count != 8'hFF) bus.drop_count <= bus.drop_count + 1'b1;
  end
`else
  assign bus.drop_count = '0;
`endif

  assign bus.wr_ready = wr_rdy;
  assign bus.rd_ready = rd_rdy;
  assign bus.level    = level_r;
  assign bus.empty    = empty_r;
  assign bus.full     = full_r;
  assign bus.ram_rst  = ~rst_n;
endmodule

// File: tb/tb_daq_ram_ctrl.sv
// Randomised scoreboard bench for daq_ram_ctrl; a queue-based FIFO model predicts grants and data.
// Honours DAQ_RAM_CTRL_DROP_EN when defined.
module tb_daq_ram_ctrl;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1024;
  localparam bit RR     = 1'b1;
`ifdef DAQ_RAM_CTRL_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  daq_ram_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  daq_ram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RR_ARB(RR)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Behavioural single-port RAM with unregistered Q
  logic [7:0] mem [DEPTH];
  initial bus.ram_q = '0;
  always @(posedge clk) begin
    if (bus.ram_ce) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      else            bus.ram_q <= mem[bus.ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: stored samples in order, abstract write/read counters
  logic [7:0] mq [$];
  exp_t       sb [$];
  int         wcnt = 0, rcnt = 0, drops = 0;
  bit         lg_w = 1'b0;
  bit         exp_ce = 1'b0, exp_we = 1'b0;
  int         exp_addr = 0;
  logic [7:0] exp_din = '0;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit wv, input logic [7:0] wd, input bit rr, input bit fl);
    bit room, we, re, wr_exp, rd_exp, gw, gr;
    @(negedge clk);
    checkOutput("level", bus.level, mq.size());
    checkOutput("full", bus.full, mq.size() == DEPTH);
    checkOutput("empty", bus.empty, mq.size() == 0);
    checkOutput("drop_count", bus.drop_count, drops);
    checkOutput("ram_ce", bus.ram_ce, exp_ce);
    if (exp_ce) begin
      checkOutput("ram_we", bus.ram_we, exp_we);
      checkOutput("ram_addr", bus.ram_addr, exp_addr);
      if (exp_we) checkOutput("ram_din", bus.ram_din, exp_din);
    end
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_req   = rr;
    bus.flush    = fl;
    #1;
    room   = (mq.size() < DEPTH) || DROP;
    we     = wv && !fl && room;
    re     = rr && !fl && (mq.size() > 0);
    wr_exp = !fl && room && !(re && RR && lg_w);
    rd_exp = !fl && (mq.size() > 0) && !(we && (!RR || !lg_w));
    checkOutput("wr_ready", bus.wr_ready, wr_exp);
    checkOutput("rd_ready", bus.rd_ready, rd_exp);
    gw = wv && wr_exp;
    gr = rr && rd_exp;
    exp_ce = 1'b0;
    exp_we = 1'b0;
    if (fl) begin
      mq.delete();
      wcnt = 0;
      rcnt = 0;
    end else if (gw) begin
      lg_w = 1'b1;
      if (mq.size() < DEPTH) begin
        mq.push_back(wd);
        exp_ce   = 1'b1;
        exp_we   = 1'b1;
        exp_addr = wcnt % DEPTH;
        exp_din  = wd;
        wcnt++;
      end else if (drops < 255) begin
        drops++;
      end
    end else if (gr) begin
      lg_w     = 1'b0;
      exp_ce   = 1'b1;
      exp_addr = rcnt % DEPTH;
      rcnt++;
      sb.push_back('{data: mq.pop_front(), due: cyc + 3});
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.rd_req   = 1'b0;
    bus.flush    = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_level", bus.level, 0);
    checkOutput("rst_empty", bus.empty, 1);
    checkOutput("rst_full", bus.full, 0);
    checkOutput("rst_ram_ce", bus.ram_ce, 0);
    checkOutput("rst_ram_we", bus.ram_we, 0);
    checkOutput("rst_ram_addr", bus.ram_addr, 0);
    checkOutput("rst_ram_din", bus.ram_din, 0);
    checkOutput("rst_rd_data", bus.rd_data, 0);
    checkOutput("rst_rd_valid", bus.rd_valid, 0);
    checkOutput("rst_drop_count", bus.drop_count, 0);
    checkOutput("rst_ram_rst", bus.ram_rst, 1);
    mq.delete();
    sb.delete();
    wcnt = 0;
    rcnt = 0;
    drops = 0;
    lg_w = 1'b0;
    exp_ce = 1'b0;
    exp_we = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 checkOutput("rel_ram_rst", bus.ram_rst, 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents read data
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rd_valid) begin
        if (sb.size() == 0) begin
          checkOutput("rd_valid_spurious", bus.rd_valid, 0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("rd_data", bus.rd_data, mon_e.data);
          checkOutput("rd_latency", cyc, mon_e.due);
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        checkOutput("rd_valid_missing", bus.rd_valid, 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_req   = 1'b0;
    bus.flush    = 1'b0;
    doReset();

    // Basic write/read of four samples
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to full, then keep pushing (stall or drop)
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Drain to level 10, then contend both sides
    for (int i = 0; i < DEPTH - 11; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b0);

    // Random traffic across pointer wrap, with occasional flush
    for (int i = 0; i < 2500; i++)
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 127) == 0));

    // Flush while a read is in flight
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset while a read is in flight; the read is lost
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Bounded drain of outstanding reads
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
